bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one bus slave port between the core's instruction-fetch requester (m0) and data load/store requester (m1).
- Allows a single outstanding transaction.
- Arbitration is either data-priority with a starvation limit, or round-robin.
- A watchdog converts a missing slave response into an error to the owning requester.

Parameters:
- DATA_PRIORITY, 1, 1 = m1 wins contested arbitration (subject to MAX_CONSEC); 0 = round-robin.
- MAX_CONSEC, 4, max consecutive contested wins for m1 before m0 is forced to win (range 1-15).
- TIMEOUT_CYCLES, 255, WAIT-state cycles without ack/err before timeout error (range 1-65535).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i  in  1  fetch request, level
- m0_we_i  in  1  write enable
- m0_addr_i  in  30  word address
- m0_wdata_i  in  32  write data
- m0_mask_i  in  4  byte mask
- m0_gnt_o  out  1  one-cycle pulse: transaction accepted by slave
- m0_rdata_o  out  32  read data
- m0_valid_o  out  1  one-cycle response pulse
- m0_err_o  out  1  one-cycle error pulse
- m1_*  same set as m0_*  data requester
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  30  slave word address
- s_wdata_o  out  32  slave write data
- s_mask_o  out  4  slave byte mask
- s_stall_i  in  1  slave cannot accept this cycle
- s_ack_i  in  1  slave completion
- s_rdata_i  in  32  slave read data
- s_err_i  in  1  slave error
- owner_o  out  1  0 = m0, 1 = m1; last/current owner
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all outputs 0.
  - owner_o = 0 (so m1 wins the first round-robin contest); consecutive-win counter 0; timeout counter 0.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any req_i is high, pick a winner, latch its we/addr/wdata/mask into payload registers, set owner_o, and go to REQ.
  - s_ack_i/s_err_i arriving in IDLE (late response) are ignored.
- Arbitration, only one requester: it wins.
- Arbitration, both requesting, DATA_PRIORITY=1:
  - m1 wins unless the consecutive counter == MAX_CONSEC, in which case m0 wins.
  - Counter increments on each contested m1 win and clears on any m0 win.
  - Uncontested m1 wins leave the counter unchanged.
- Arbitration, both requesting, DATA_PRIORITY=0: the requester that is not owner_o wins.
- REQ:
  - s_req_o = 1 and s_* are driven from the latched payload (stable while stalled).
  - If s_stall_i is low: pulse the owner's gnt_o this cycle, clear the timeout counter, go to WAIT.
  - Ack/err seen in REQ is ignored.
- WAIT:
  - s_req_o = 0; timeout counter increments each cycle.
  - On s_ack_i or s_err_i: register the response and go to IDLE.
  - Next cycle, owner's rdata_o = s_rdata_i, and exactly one of valid_o or err_o pulses.
  - If ack and err are both high, err wins: err_o=1, valid_o=0, rdata_o unchanged.
  - If the counter reaches TIMEOUT_CYCLES with no response: owner's err_o pulses next cycle; go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES in the same cycle as an ack/err, the slave response takes precedence.
- rdata_o holds its value until the next valid response to that requester; the non-owner's outputs stay 0 (rdata held).
- Latency, no stall:
  - req in IDLE at cycle 0 → s_req_o and gnt at cycle 1.
  - Earliest ack at cycle 2 → valid_o at cycle 3.
  - FSM is back in IDLE at cycle 3 and can latch a new request the same cycle; s_req_o of the next transaction at cycle 4.
- Protocol: a requester holds req_i and its payload until gnt_o. Dropping req_i after the latch does not cancel; the transaction completes and its response is delivered.
- The timeout counter is sized to hold TIMEOUT_CYCLES and saturates; it never wraps.

Test Plan:
1. Single m0 read, no stall, ack one cycle after gnt with rdata 0xDEADBEEF → s_req_o at cycle 1, m0_gnt_o at cycle 1, m0_valid_o at cycle 3 with rdata 0xDEADBEEF; m1 outputs all 0.
2. DATA_PRIORITY=1, MAX_CONSEC=4, both requesters continuously high with immediate acks → grant order m1,m1,m1,m1,m0,m1,m1,m1,m1,m0.
3. DATA_PRIORITY=0, both requesters continuously high → grants alternate starting with m1 (owner_o resets to 0).
4. m1 write, addr 0x0000_0010, mask 4'b0011, s_stall_i high for 3 cycles → s_addr/s_wdata/s_mask stable during all 3 stalled cycles; m1_gnt_o only in the first unstalled cycle.
5. TIMEOUT_CYCLES=8, slave never acks → m0_err_o pulses 9 cycles after gnt; a late s_ack_i afterwards is ignored; the next request is serviced normally.
6. Simultaneous s_ack_i and s_err_i → err_o=1, valid_o=0. Separately, rst_n asserted in WAIT → all outputs 0 asynchronously, and no response pulse after rst_n deasserts.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bus slave port between the instruction-fetch
// requester (m0) and the data load/store requester (m1). One transaction is
// outstanding at a time. Contested arbitration is either data-priority with a
// starvation limit or round-robin. A watchdog turns a missing slave response
// into an error pulse for the owning requester.

module bus_arbiter #(
  parameter int unsigned DATA_PRIORITY  = 1,
  parameter int unsigned MAX_CONSEC     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  // fetch requester
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [29:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_mask_i,
  output logic        m0_gnt_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_valid_o,
  output logic        m0_err_o,

  // data requester
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [29:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_mask_i,
  output logic        m1_gnt_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_valid_o,
  output logic        m1_err_o,

  // slave port
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_mask_o,
  input  logic        s_stall_i,
  input  logic        s_ack_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i,

  // status
  output logic        owner_o,
  output logic        busy_o
);

  // Watchdog width: must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    CONSEC_LIM = 4'(MAX_CONSEC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    consec_q, consec_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // latched payload of the winning requester
  logic          pl_we_q, pl_we_d;
  logic [29:0]   pl_addr_q, pl_addr_d;
  logic [31:0]   pl_wdata_q, pl_wdata_d;
  logic [3:0]    pl_mask_q, pl_mask_d;

  // per-requester response registers
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic          m0_valid_q, m0_valid_d;
  logic          m0_err_q, m0_err_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          m1_valid_q, m1_valid_d;
  logic          m1_err_q, m1_err_d;

  logic          win_s;
  logic          in_req_s;
  logic          gnt_s;

  // Next-state, arbitration, payload latch, watchdog and response capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    consec_d   = consec_q;
    tmo_d      = tmo_q;
    pl_we_d    = pl_we_q;
    pl_addr_d  = pl_addr_q;
    pl_wdata_d = pl_wdata_q;
    pl_mask_d  = pl_mask_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_valid_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_valid_d = 1'b0;
    m1_err_d   = 1'b0;
    win_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          if (m0_req_i && m1_req_i) begin
            if (DATA_PRIORITY != 32'd0) begin
              // m1 wins contests until it has taken MAX_CONSEC in a row
              if (consec_q >= CONSEC_LIM) begin
                win_s = 1'b0;
              end else begin
                win_s = 1'b1;
              end
            end else begin
              // round-robin: whoever did not own the bus last
              win_s = ~owner_q;
            end
          end else begin
            win_s = m1_req_i;
          end

          // starvation counter: any m0 win clears, contested m1 win counts
          if (!win_s) begin
            consec_d = 4'd0;
          end else if (m0_req_i && (consec_q != 4'd15)) begin
            consec_d = consec_q + 4'd1;
          end else begin
            consec_d = consec_q;
          end

          owner_d    = win_s;
          pl_we_d    = win_s ? m1_we_i    : m0_we_i;
          pl_addr_d  = win_s ? m1_addr_i  : m0_addr_i;
          pl_wdata_d = win_s ? m1_wdata_i : m0_wdata_i;
          pl_mask_d  = win_s ? m1_mask_i  : m0_mask_i;
          state_d    = ST_REQ;
        end else begin
          // late ack/err from an abandoned transaction is dropped here
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (!s_stall_i) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_WAIT: begin
        // saturating watchdog, never wraps
        if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TW'(1'b1);
        end else begin
          tmo_d = tmo_q;
        end

        if (s_ack_i || s_err_i) begin
          // a real slave response beats a coincident timeout; err beats ack
          state_d = ST_IDLE;
          if (s_err_i) begin
            if (owner_q) begin
              m1_err_d = 1'b1;
            end else begin
              m0_err_d = 1'b1;
            end
          end else begin
            if (owner_q) begin
              m1_valid_d = 1'b1;
              m1_rdata_d = s_rdata_i;
            end else begin
              m0_valid_d = 1'b1;
              m0_rdata_d = s_rdata_i;
            end
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            m1_err_d = 1'b1;
          end else begin
            m0_err_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, payload and response registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      consec_q   <= 4'd0;
      tmo_q      <= '0;
      pl_we_q    <= 1'b0;
      pl_addr_q  <= 30'd0;
      pl_wdata_q <= 32'd0;
      pl_mask_q  <= 4'd0;
      m0_rdata_q <= 32'd0;
      m0_valid_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_rdata_q <= 32'd0;
      m1_valid_q <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      consec_q   <= consec_d;
      tmo_q      <= tmo_d;
      pl_we_q    <= pl_we_d;
      pl_addr_q  <= pl_addr_d;
      pl_wdata_q <= pl_wdata_d;
      pl_mask_q  <= pl_mask_d;
      m0_rdata_q <= m0_rdata_d;
      m0_valid_q <= m0_valid_d;
      m0_err_q   <= m0_err_d;
      m1_rdata_q <= m1_rdata_d;
      m1_valid_q <= m1_valid_d;
      m1_err_q   <= m1_err_d;
    end
  end

  // Slave side is driven only in REQ, straight from the latched payload,
  // so it stays stable for as long as the slave stalls.
  assign in_req_s  = (state_q == ST_REQ);
  assign gnt_s     = in_req_s && !s_stall_i;

  assign s_req_o   = in_req_s;
  assign s_we_o    = in_req_s ? pl_we_q    : 1'b0;
  assign s_addr_o  = in_req_s ? pl_addr_q  : 30'd0;
  assign s_wdata_o = in_req_s ? pl_wdata_q : 32'd0;
  assign s_mask_o  = in_req_s ? pl_mask_q  : 4'd0;

  // Grant is the accept handshake, so it must follow s_stall_i in-cycle.
  assign m0_gnt_o  = gnt_s & ~owner_q;
  assign m1_gnt_o  = gnt_s &  owner_q;

  assign m0_rdata_o = m0_rdata_q;
  assign m0_valid_o = m0_valid_q;
  assign m0_err_o   = m0_err_q;
  assign m1_rdata_o = m1_rdata_q;
  assign m1_valid_o = m1_valid_q;
  assign m1_err_o   = m1_err_q;

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. dut_a is data-priority (MAX_CONSEC=4,
// TIMEOUT_CYCLES=8); dut_b is round-robin and shares all inputs with dut_a.
// Expected grants and responses are queued when stimulus is driven and
// popped by a monitor when the DUT produces them.

module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_rdata;

  logic        a_m0_gnt, a_m0_valid, a_m0_err, a_m1_gnt, a_m1_valid, a_m1_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
  logic        a_s_req, a_s_we, a_owner, a_busy;
  logic [29:0] a_s_addr;
  logic [3:0]  a_s_mask;

  logic        b_m0_gnt, b_m0_valid, b_m0_err, b_m1_gnt, b_m1_valid, b_m1_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic        b_s_req, b_s_we, b_owner, b_busy;
  logic [29:0] b_s_addr;
  logic [3:0]  b_s_mask;

  bus_arbiter #(.DATA_PRIORITY(1), .MAX_CONSEC(4), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_mask_i(m0_mask), .m0_gnt_o(a_m0_gnt), .m0_rdata_o(a_m0_rdata),
    .m0_valid_o(a_m0_valid), .m0_err_o(a_m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_mask_i(m1_mask), .m1_gnt_o(a_m1_gnt), .m1_rdata_o(a_m1_rdata),
    .m1_valid_o(a_m1_valid), .m1_err_o(a_m1_err),
    .s_req_o(a_s_req), .s_we_o(a_s_we), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
    .s_mask_o(a_s_mask), .s_stall_i(s_stall), .s_ack_i(s_ack), .s_rdata_i(s_rdata),
    .s_err_i(s_err), .owner_o(a_owner), .busy_o(a_busy)
  );

  bus_arbiter #(.DATA_PRIORITY(0), .MAX_CONSEC(4), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_mask_i(m0_mask), .m0_gnt_o(b_m0_gnt), .m0_rdata_o(b_m0_rdata),
    .m0_valid_o(b_m0_valid), .m0_err_o(b_m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_mask_i(m1_mask), .m1_gnt_o(b_m1_gnt), .m1_rdata_o(b_m1_rdata),
    .m1_valid_o(b_m1_valid), .m1_err_o(b_m1_err),
    .s_req_o(b_s_req), .s_we_o(b_s_we), .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata),
    .s_mask_o(b_s_mask), .s_stall_i(s_stall), .s_ack_i(s_ack), .s_rdata_i(s_rdata),
    .s_err_i(s_err), .owner_o(b_owner), .busy_o(b_busy)
  );

  typedef struct packed {
    logic        who;
    logic        is_err;
    logic [31:0] rdata;
  } resp_t;

  int    errors = 0;
  int    checks = 0;
  logic  ga_q[$];
  logic  gb_q[$];
  resp_t ra_q[$];
  logic  rr_mon = 1'b0;
  logic [31:0] last_rd0, last_rd1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_ok(input logic who, input logic [31:0] rd);
    resp_t e;
    if (who) last_rd1 = rd; else last_rd0 = rd;
    e.who = who; e.is_err = 1'b0; e.rdata = rd;
    ra_q.push_back(e);
  endtask

  task automatic push_err(input logic who);
    resp_t e;
    e.who = who; e.is_err = 1'b1; e.rdata = who ? last_rd1 : last_rd0;
    ra_q.push_back(e);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 30'd0; m0_wdata = 32'd0; m0_mask = 4'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 30'd0; m1_wdata = 32'd0; m1_mask = 4'd0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'd0;
    last_rd0 = 32'd0; last_rd1 = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: grants and responses checked against queued expectations.
  always @(negedge clk) begin
    logic [1:0]  exp_g;
    logic [3:0]  exp_f;
    logic [31:0] obs_rd;
    resp_t       e;
    if (a_m0_gnt || a_m1_gnt) begin
      exp_g = 2'b00;
      if (ga_q.size() != 0) exp_g = ga_q.pop_front() ? 2'b10 : 2'b01;
      checks++;
      assert ({a_m1_gnt, a_m0_gnt} === exp_g) else begin
        errors++;
        $error("FAIL gnt_a observed=%b expected=%b", {a_m1_gnt, a_m0_gnt}, exp_g);
      end
    end
    if (rr_mon && (b_m0_gnt || b_m1_gnt)) begin
      exp_g = 2'b00;
      if (gb_q.size() != 0) exp_g = gb_q.pop_front() ? 2'b10 : 2'b01;
      checks++;
      assert ({b_m1_gnt, b_m0_gnt} === exp_g) else begin
        errors++;
        $error("FAIL gnt_rr observed=%b expected=%b", {b_m1_gnt, b_m0_gnt}, exp_g);
      end
    end
    if (a_m0_valid || a_m0_err || a_m1_valid || a_m1_err) begin
      e = '0;
      exp_f = 4'b0000;
      if (ra_q.size() != 0) begin
        e = ra_q.pop_front();
        exp_f = e.who ? (e.is_err ? 4'b1000 : 4'b0100) : (e.is_err ? 4'b0010 : 4'b0001);
      end
      obs_rd = e.who ? a_m1_rdata : a_m0_rdata;
      checks++;
      assert ({a_m1_err, a_m1_valid, a_m0_err, a_m0_valid, obs_rd} === {exp_f, e.rdata}) else begin
        errors++;
        $error("FAIL resp_a observed=%b/%h expected=%b/%h",
               {a_m1_err, a_m1_valid, a_m0_err, a_m0_valid}, obs_rd, exp_f, e.rdata);
      end
    end
  end

  initial begin
    do_reset();
    // reset state
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_owner", a_owner, 1'b0);
    chk1("rst_sreq", a_s_req, 1'b0);
    chkw("rst_m0_rdata", a_m0_rdata, 32'd0);
    chkw("rst_m1_rdata", a_m1_rdata, 32'd0);
    chkw("rst_saddr", 32'(a_s_addr), 32'd0);

    // 1: single m0 read, ack one cycle after grant
    nx(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h100; ga_q.push_back(1'b0);
    smp(); chk1("t1_c0_sreq", a_s_req, 1'b0); chk1("t1_c0_gnt", a_m0_gnt, 1'b0);
    nx();
    smp(); chk1("t1_c1_sreq", a_s_req, 1'b1); chk1("t1_c1_gnt", a_m0_gnt, 1'b1);
    chkw("t1_c1_addr", 32'(a_s_addr), 32'h100); chk1("t1_c1_m1gnt", a_m1_gnt, 1'b0);
    nx(); m0_req = 1'b0; s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; push_ok(1'b0, 32'hDEAD_BEEF);
    smp(); chk1("t1_c2_sreq", a_s_req, 1'b0); chk1("t1_c2_busy", a_busy, 1'b1);
    nx(); s_ack = 1'b0; s_rdata = 32'd0;
    smp(); chk1("t1_c3_valid", a_m0_valid, 1'b1); chkw("t1_c3_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    chk1("t1_c3_m1valid", a_m1_valid, 1'b0); chk1("t1_c3_m1err", a_m1_err, 1'b0);
    chkw("t1_c3_m1rdata", a_m1_rdata, 32'd0); chk1("t1_c3_busy", a_busy, 1'b0);
    nx();
    smp(); chk1("t1_c4_valid", a_m0_valid, 1'b0); chkw("t1_c4_rdata", a_m0_rdata, 32'hDEAD_BEEF);

    // 2+3: both requesting continuously, immediate acks
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ga_q.push_back((i % 5) != 4);
      gb_q.push_back((i % 2) == 0);
      push_ok((i % 5) != 4, 32'h1357_9BDF);
    end
    rr_mon = 1'b1;
    nx(); m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h20;
    s_ack = 1'b1; s_rdata = 32'h1357_9BDF;
    smp();
    for (int c = 1; c <= 30; c++) begin
      nx();
      if (c == 29) begin m0_req = 1'b0; m1_req = 1'b0; end
      smp();
    end
    nx(); s_ack = 1'b0; rr_mon = 1'b0;
    smp(); chkw("t2_gnt_left", 32'(ga_q.size()), 32'd0); chkw("t3_gnt_left", 32'(gb_q.size()), 32'd0);
    chkw("t2_resp_left", 32'(ra_q.size()), 32'd0); chk1("t2_busy", a_busy, 1'b0);

    // 4: m1 write stalled for three cycles
    nx(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h10; m1_wdata = 32'hCAFE_F00D;
    m1_mask = 4'b0011; s_stall = 1'b1; ga_q.push_back(1'b1);
    smp();
    for (int c = 1; c <= 3; c++) begin
      nx();
      smp(); chk1("t4_stall_sreq", a_s_req, 1'b1); chkw("t4_stall_addr", 32'(a_s_addr), 32'h10);
      chkw("t4_stall_wdata", a_s_wdata, 32'hCAFE_F00D); chkw("t4_stall_mask", 32'(a_s_mask), 32'h3);
      chk1("t4_stall_we", a_s_we, 1'b1); chk1("t4_stall_gnt", a_m1_gnt, 1'b0);
    end
    nx(); s_stall = 1'b0;
    smp(); chk1("t4_gnt", a_m1_gnt, 1'b1); chk1("t4_m0gnt", a_m0_gnt, 1'b0);
    chkw("t4_gnt_addr", 32'(a_s_addr), 32'h10);
    nx(); m1_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h5555_AAAA; push_ok(1'b1, 32'h5555_AAAA);
    smp();
    nx(); s_ack = 1'b0;
    smp(); chk1("t4_valid", a_m1_valid, 1'b1); chkw("t4_rdata", a_m1_rdata, 32'h5555_AAAA);

    // 5: watchdog, late ack ignored, next request normal
    nx(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h200; ga_q.push_back(1'b0); push_err(1'b0);
    smp();
    nx();
    smp(); chk1("t5_gnt", a_m0_gnt, 1'b1);
    for (int c = 2; c <= 10; c++) begin
      nx();
      if (c == 2) m0_req = 1'b0;
      smp(); chk1("t5_err_timing", a_m0_err, c == 10); chk1("t5_busy", a_busy, c != 10);
    end
    nx(); s_ack = 1'b1; s_rdata = 32'hBAD0_BAD0;
    smp(); chk1("t5_late_busy", a_busy, 1'b0);
    nx(); s_ack = 1'b0;
    smp(); chk1("t5_late_valid", a_m0_valid, 1'b0); chkw("t5_late_rdata", a_m0_rdata, 32'h1357_9BDF);
    nx(); m0_req = 1'b1; m0_addr = 30'h201; ga_q.push_back(1'b0);
    smp();
    nx();
    smp(); chk1("t5_next_gnt", a_m0_gnt, 1'b1); chkw("t5_next_addr", 32'(a_s_addr), 32'h201);
    nx(); m0_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h0BAD_F00D; push_ok(1'b0, 32'h0BAD_F00D);
    smp();
    nx(); s_ack = 1'b0;
    smp(); chk1("t5_next_valid", a_m0_valid, 1'b1);

    // 6a: simultaneous ack and err, err wins and rdata holds
    nx(); m1_req = 1'b1; m1_we = 1'b0; ga_q.push_back(1'b1); push_err(1'b1);
    smp();
    nx();
    smp();
    nx(); m1_req = 1'b0; s_ack = 1'b1; s_err = 1'b1; s_rdata = 32'hFFFF_0000;
    smp();
    nx(); s_ack = 1'b0; s_err = 1'b0;
    smp(); chk1("t6_err", a_m1_err, 1'b1); chk1("t6_valid", a_m1_valid, 1'b0);
    chkw("t6_rdata", a_m1_rdata, 32'h5555_AAAA);

    // 6b: async reset while waiting for a response
    nx(); m0_req = 1'b1; ga_q.push_back(1'b0);
    smp();
    nx();
    smp();
    nx(); m0_req = 1'b0;
    chk1("t6_wait_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_busy", a_busy, 1'b0); chk1("t6_rst_owner", a_owner, 1'b0);
    chk1("t6_rst_sreq", a_s_req, 1'b0); chkw("t6_rst_m0rd", a_m0_rdata, 32'd0);
    chkw("t6_rst_m1rd", a_m1_rdata, 32'd0); chk1("t6_rst_m1err", a_m1_err, 1'b0);
    last_rd0 = 32'd0; last_rd1 = 32'd0;
    s_ack = 1'b1;
    smp(); rst_n = 1'b1; s_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nx();
      smp(); chk1("t6_post_valid", a_m0_valid, 1'b0); chk1("t6_post_err", a_m0_err, 1'b0);
      chk1("t6_post_busy", a_busy, 1'b0);
    end
    chkw("end_gnt_left", 32'(ga_q.size()), 32'd0);
    chkw("end_resp_left", 32'(ra_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
